// File: rtl/sram_io_host.sv
`default_nettype none
// ============================================================================
// Module   : sram_io_host
// Brief    : Host-side serial driver for the SRAM serial I/O controller.
//            Serialises write/read commands onto SI/LOAD_N/CTRL and shifts
//            read data back in from SO.
// Revision : 1.0 - initial release
// ============================================================================
module sram_io_host #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int SLOT_CYCLES       = 6,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                         CLK,
    input  logic                         BGN,
    input  logic                         CMD_VLD,
    output logic                         CMD_RDY,
    input  logic                         CMD_WR,
    input  logic [MEMORY_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [MEMORY_DATA_WIDTH-1:0] CMD_WDATA,
    output logic                         RSP_VLD,
    output logic                         RSP_ERR,
    output logic [MEMORY_DATA_WIDTH-1:0] RSP_RDATA,
    output logic                         SI,
    output logic                         LOAD_N,
    output logic [1:0]                   CTRL,
    input  logic                         SO,
    input  logic                         RDY
);

    localparam int SHIFT_BITS = MEMORY_DATA_WIDTH + MEMORY_ADDR_WIDTH;
    localparam int SLOT_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BIT_W      = $clog2(SHIFT_BITS);

    localparam logic [SLOT_W-1:0] C_SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] C_SLOT_ONE   = SLOT_W'(1);
    localparam logic [TMO_W-1:0]  C_TMO_LAST   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  C_TMO_ONE    = TMO_W'(1);
    localparam logic [BIT_W-1:0]  C_SHIFT_LAST = BIT_W'(SHIFT_BITS - 1);
    localparam logic [BIT_W-1:0]  C_RDBK_LAST  = BIT_W'(MEMORY_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  C_BIT_ONE    = BIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_RDBK  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                         state_q,     state_d;
    logic [SLOT_W-1:0]              slot_cnt_q,  slot_cnt_d;
    logic [TMO_W-1:0]               tmo_cnt_q,   tmo_cnt_d;
    logic [BIT_W-1:0]               bit_cnt_q,   bit_cnt_d;
    logic [SHIFT_BITS-1:0]          sreg_q,      sreg_d;
    logic                           wr_q,        wr_d;
    logic                           err_q,       err_d;
    logic [MEMORY_DATA_WIDTH-1:0]   rd_shadow_q, rd_shadow_d;
    logic [MEMORY_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                           w_in_slot;
    logic                           w_slot_max;
    logic [MEMORY_DATA_WIDTH-1:0]   w_rd_next;

    assign w_in_slot  = (state_q == ST_SHIFT) || (state_q == ST_EXEC) || (state_q == ST_RDBK);
    assign w_slot_max = (slot_cnt_q == C_SLOT_LAST);
    // Read bits arrive LSB first, so shift them in at the top.
    assign w_rd_next  = {SO, rd_shadow_q[MEMORY_DATA_WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sreg_d      = sreg_q;
        wr_d        = wr_q;
        err_d       = err_q;
        rd_shadow_d = rd_shadow_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VLD) begin
                    state_d     = ST_SHIFT;
                    sreg_d      = {CMD_ADDR, (CMD_WR ? CMD_WDATA : '0)};
                    wr_d        = CMD_WR;
                    err_d       = 1'b0;
                    slot_cnt_d  = '0;
                    tmo_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    rd_shadow_d = '0;
                end
            end
            ST_SHIFT, ST_EXEC, ST_RDBK: begin
                if (!w_slot_max) begin
                    slot_cnt_d = slot_cnt_q + C_SLOT_ONE;
                end else if (!RDY) begin
                    if (tmo_cnt_q == C_TMO_LAST) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + C_TMO_ONE;
                    end
                end else begin
                    slot_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    bit_cnt_d  = bit_cnt_q + C_BIT_ONE;
                    case (state_q)
                        ST_SHIFT: begin
                            sreg_d = sreg_q >> 1;
                            if (bit_cnt_q == C_SHIFT_LAST) begin
                                bit_cnt_d = '0;
                                state_d   = ST_EXEC;
                            end
                        end
                        ST_EXEC: begin
                            if (wr_q) begin
                                state_d = ST_DONE;
                            end else begin
                                rd_shadow_d = w_rd_next;
                                bit_cnt_d   = C_BIT_ONE;
                                state_d     = ST_RDBK;
                            end
                        end
                        default: begin
                            rd_shadow_d = w_rd_next;
                            if (bit_cnt_q == C_RDBK_LAST) begin
                                rsp_rdata_d = w_rd_next;
                                state_d     = ST_DONE;
                            end
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge BGN) begin
        if (!BGN) begin
            state_q     <= ST_IDLE;
            slot_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            rd_shadow_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sreg_q      <= sreg_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            rd_shadow_q <= rd_shadow_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign CMD_RDY   = (state_q == ST_IDLE);
    assign RSP_VLD   = (state_q == ST_DONE);
    assign RSP_ERR   = (state_q == ST_DONE) && err_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign LOAD_N    = !(w_in_slot && (slot_cnt_q == '0));
    assign SI        = (state_q == ST_SHIFT) ? sreg_q[0] : 1'b0;
    assign CTRL      = (state_q == ST_EXEC) ? (wr_q ? 2'b11 : 2'b01) : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_sram_io_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_io_host
// Brief    : Self-checking bench for sram_io_host with a behavioural model of
//            the SRAM serial controller and a reference memory scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_io_host;

    localparam int C_DW      = 8;
    localparam int C_AW      = 9;
    localparam int C_SLOT    = 6;
    localparam int C_TMO     = 64;
    localparam int C_NSHIFT  = C_DW + C_AW;
    localparam int C_NWORDS  = 1 << C_AW;

    logic              clk = 1'b0;
    logic              bgn;
    logic              cmd_vld;
    logic              cmd_rdy;
    logic              cmd_wr;
    logic [C_AW-1:0]   cmd_addr;
    logic [C_DW-1:0]   cmd_wdata;
    logic              rsp_vld;
    logic              rsp_err;
    logic [C_DW-1:0]   rsp_rdata;
    logic              si;
    logic              load_n;
    logic [1:0]        ctrl;
    logic              so;
    logic              rdy = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    sram_io_host #(
        .MEMORY_DATA_WIDTH (C_DW),
        .MEMORY_ADDR_WIDTH (C_AW),
        .SLOT_CYCLES       (C_SLOT),
        .TIMEOUT_CYCLES    (C_TMO)
    ) u_dut (
        .CLK       (clk),
        .BGN       (bgn),
        .CMD_VLD   (cmd_vld),
        .CMD_RDY   (cmd_rdy),
        .CMD_WR    (cmd_wr),
        .CMD_ADDR  (cmd_addr),
        .CMD_WDATA (cmd_wdata),
        .RSP_VLD   (rsp_vld),
        .RSP_ERR   (rsp_err),
        .RSP_RDATA (rsp_rdata),
        .SI        (si),
        .LOAD_N    (load_n),
        .CTRL      (ctrl),
        .SO        (so),
        .RDY       (rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [C_DW-1:0] init_val(input logic [C_AW-1:0] a);
        return a[7:0] ^ 8'h5A ^ {7'd0, a[8]};
    endfunction

    // ---------------- serial controller model (acts mid-cycle) -------------
    logic [C_DW-1:0]     mem [C_NWORDS];
    bit                  mem_init = 1'b0;
    logic [C_NSHIFT-1:0] m_sr     = '0;
    logic [C_DW-1:0]     m_rd_sr  = '0;
    int                  slot_idx = 0;
    int                  low_cnt  = 0;
    bit                  stuck    = 1'b0;
    int                  stab_err = 0;
    int                  rsp_cnt  = 0;
    logic                cur_si   = 1'b0;
    logic [1:0]          cur_ctrl = 2'b00;
    logic                obs_si   [32];
    logic [1:0]          obs_ctrl [32];
    int                  cfg_st_slot = -1;
    int                  cfg_st_len  = 0;
    int                  cfg_stuck   = -1;

    assign so = m_rd_sr[0];

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < C_NWORDS; i++) mem[C_AW'(i)] = init_val(C_AW'(i));
            mem_init = 1'b1;
        end
        if (!bgn || cmd_rdy) begin
            slot_idx = 0;
            low_cnt  = 0;
            stuck    = 1'b0;
            stab_err = 0;
        end else if (!load_n) begin
            case (ctrl)
                2'b00: begin
                    m_sr    = {si, m_sr[C_NSHIFT-1:1]};
                    m_rd_sr = m_rd_sr >> 1;
                end
                2'b11:   mem[m_sr[C_NSHIFT-1:C_DW]] = m_sr[C_DW-1:0];
                2'b01:   m_rd_sr = mem[m_sr[C_NSHIFT-1:C_DW]];
                default: ;
            endcase
            if (slot_idx < 32) begin
                obs_si[5'(slot_idx)]   = si;
                obs_ctrl[5'(slot_idx)] = ctrl;
            end
            cur_si   = si;
            cur_ctrl = ctrl;
            if (slot_idx == cfg_st_slot) low_cnt = C_SLOT - 1 + cfg_st_len;
            if (cfg_stuck >= 0 && slot_idx >= cfg_stuck) stuck = 1'b1;
            slot_idx++;
        end else if (!rsp_vld && (si !== cur_si || ctrl !== cur_ctrl)) begin
            stab_err++;
        end
        if (stuck && !cmd_rdy) begin
            rdy = 1'b0;
        end else if (low_cnt > 0) begin
            rdy = 1'b0;
            low_cnt--;
        end else begin
            rdy = 1'b1;
        end
        if (rsp_vld) rsp_cnt++;
    end

    // ---------------- checking ----------------------------------------------
    logic [C_DW-1:0] ref_mem [C_NWORDS];
    logic [C_DW-1:0] last_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check_eq("idle_after_rsp", 32'({cmd_rdy, rsp_vld, load_n, ctrl}), 32'({1'b1, 1'b0, 1'b1, 2'b00}));
    endtask

    // Issues one command and checks its response in the RSP_VLD cycle.
    task automatic run_cmd(input bit wr, input logic [C_AW-1:0] addr, input logic [C_DW-1:0] data,
                           input int st_slot, input int st_len, input int stuck_at,
                           input int keep, input bit b2b);
        int                  waits;
        int                  n;
        int                  n_slots;
        int                  exp_lat;
        bit                  to_case;
        logic [C_NSHIFT-1:0] stream;
        logic [1:0]          ctrl_or;
        logic                si_or;
        logic [C_DW-1:0]     exp_rd;
        cfg_st_slot = st_slot;
        cfg_st_len  = st_len;
        cfg_stuck   = stuck_at;
        cmd_vld   = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        waits = 0;
        while (!cmd_rdy && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (b2b) check_eq("b2b_accept_wait", 32'(waits), 32'd1);
        @(negedge clk);
        n = 1;
        do begin
            if (n > keep) begin
                cmd_vld = 1'b0;
            end else begin
                cmd_addr  = C_AW'($urandom);
                cmd_wdata = C_DW'($urandom);
                cmd_wr    = ~wr;
            end
            if (!rsp_vld) begin
                @(negedge clk);
                n++;
            end
        end while (!rsp_vld && n < 3000);
        cmd_vld = 1'b0;

        to_case = (stuck_at >= 0);
        n_slots = wr ? C_NSHIFT + 1 : C_NSHIFT + C_DW;
        if (to_case) begin
            n_slots = stuck_at + 1;
            exp_lat = n_slots * C_SLOT + C_TMO + 1;
        end else begin
            exp_lat = n_slots * C_SLOT + 1 + ((st_slot >= 0 && st_slot < n_slots) ? st_len : 0);
        end
        exp_rd = (!wr && !to_case) ? ref_mem[addr] : last_rd;

        check_eq("rsp_seen", 32'(rsp_vld), 32'd1);
        check_eq("rsp_latency", 32'(n), 32'(exp_lat));
        check_eq("rsp_err", 32'(rsp_err), 32'(to_case));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check_eq("load_pulses", 32'(slot_idx), 32'(n_slots));
        check_eq("done_pins", 32'({load_n, ctrl, cmd_rdy}), 32'({1'b1, 2'b00, 1'b0}));
        check_eq("slot_stable", 32'(stab_err), 32'd0);
        if (!to_case) begin
            stream  = '0;
            ctrl_or = 2'b00;
            for (int i = 0; i < C_NSHIFT; i++) begin
                stream  = {obs_si[5'(i)], stream[C_NSHIFT-1:1]};
                ctrl_or = ctrl_or | obs_ctrl[5'(i)];
            end
            check_eq("si_stream", 32'(stream), 32'({addr, (wr ? data : C_DW'(0))}));
            check_eq("shift_ctrl", 32'(ctrl_or), 32'd0);
            check_eq("exec_ctrl", 32'(obs_ctrl[5'(C_NSHIFT)]), wr ? 32'd3 : 32'd1);
            if (!wr) begin
                si_or   = 1'b0;
                ctrl_or = 2'b00;
                for (int i = C_NSHIFT + 1; i < C_NSHIFT + C_DW; i++) begin
                    si_or   = si_or | obs_si[5'(i)];
                    ctrl_or = ctrl_or | obs_ctrl[5'(i)];
                end
                check_eq("rdbk_pins", 32'({si_or, ctrl_or}), 32'd0);
                last_rd = exp_rd;
            end else begin
                ref_mem[addr] = data;
            end
        end
    endtask

    initial begin
        int  rsp_before;
        bit  prev_nb;
        bit  nb;
        for (int i = 0; i < C_NWORDS; i++) ref_mem[C_AW'(i)] = init_val(C_AW'(i));
        bgn       = 1'b0;
        cmd_vld   = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_pins", 32'({cmd_rdy, rsp_vld, rsp_err, load_n, si, ctrl}),
                 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}));
        check_eq("reset_rdata", 32'(rsp_rdata), 32'd0);
        bgn = 1'b1;
        @(negedge clk);

        // Directed: basic write/read pairs
        run_cmd(1'b1, 9'h1A5, 8'h3C, -1, 0, -1, 0, 1'b0); idle_check();
        run_cmd(1'b0, 9'h1A5, 8'h00, -1, 0, -1, 3, 1'b0); idle_check();
        run_cmd(1'b1, 9'h0FF, 8'hA7, -1, 0, -1, 0, 1'b0); idle_check();
        run_cmd(1'b0, 9'h0FF, 8'h00, -1, 0, -1, 0, 1'b0); idle_check();
        // Back-to-back: read presented during the write's response cycle
        run_cmd(1'b1, 9'h055, 8'hFF, -1, 0, -1, 0, 1'b0);
        run_cmd(1'b0, 9'h055, 8'h00, -1, 0, -1, 0, 1'b1); idle_check();
        // Stretched RDY in the third slot
        run_cmd(1'b1, 9'h123, 8'h96, 2, 10, -1, 0, 1'b0); idle_check();
        run_cmd(1'b0, 9'h123, 8'h00, 2, 10, -1, 0, 1'b0); idle_check();
        // RDY stuck low from the second slot onward
        run_cmd(1'b1, 9'h0AA, 8'h11, -1, 0, 1, 0, 1'b0); idle_check();
        run_cmd(1'b0, 9'h0AA, 8'h00, -1, 0, -1, 0, 1'b0); idle_check();

        // Asynchronous reset in the middle of a shift phase
        cfg_st_slot = -1;
        cfg_stuck   = -1;
        cmd_vld   = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 9'h0AA;
        cmd_wdata = 8'hEE;
        @(negedge clk);
        cmd_vld = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("busy_before_reset", 32'(cmd_rdy), 32'd0);
        rsp_before = rsp_cnt;
        #2 bgn = 1'b0;
        #1;
        check_eq("async_reset_pins", 32'({cmd_rdy, rsp_vld, rsp_err, load_n, si, ctrl}),
                 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}));
        check_eq("async_reset_rdata", 32'(rsp_rdata), 32'd0);
        last_rd = '0;
        @(negedge clk);
        bgn = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("no_rsp_after_reset", 32'(rsp_cnt - rsp_before), 32'd0);
        run_cmd(1'b0, 9'h0AA, 8'h00, -1, 0, -1, 0, 1'b0); idle_check();

        // Randomized traffic over a small address pool so reads hit writes
        prev_nb = 1'b0;
        for (int k = 0; k < 14; k++) begin
            nb = 1'(($urandom_range(0, 2) == 0) && (k < 13));
            run_cmd(1'($urandom_range(0, 1)),
                    C_AW'($urandom_range(0, 7) * 64 + $urandom_range(0, 3)),
                    C_DW'($urandom),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 24)) : -1,
                    int'($urandom_range(0, 20)),
                    -1,
                    int'($urandom_range(0, 20)),
                    prev_nb);
            if (!nb) idle_check();
            prev_nb = nb;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_io_host.md
Name: sram_io_host

Overview:
Host-side serial driver for the SRAM serial I/O controller. It accepts parallel SRAM write or read commands on a valid/ready interface. It serialises the address and data onto SI, pulses LOAD_N with the CTRL code for each transfer slot, and for reads shifts the SRAM word back in from SO. It sits between the test/CPU-load logic and the controller's serial pins.

Parameters:
MEMORY_DATA_WIDTH, 8, SRAM data width.
MEMORY_ADDR_WIDTH, 9, SRAM address width.
SLOT_CYCLES, 6, minimum cycles per serial slot; must be at least 5.
TIMEOUT_CYCLES, 64, extra cycles allowed waiting for RDY after a slot's minimum length.

Ports:
CLK  in  1  clock; all logic on posedge.
BGN  in  1  asynchronous active-low reset.
CMD_VLD  in  1  command valid.
CMD_RDY  out  1  command accepted when CMD_VLD && CMD_RDY.
CMD_WR  in  1  1 = write, 0 = read.
CMD_ADDR  in  MEMORY_ADDR_WIDTH  SRAM address.
CMD_WDATA  in  MEMORY_DATA_WIDTH  write data; ignored for reads.
RSP_VLD  out  1  one-cycle pulse when a command completes.
RSP_ERR  out  1  valid with RSP_VLD; 1 = RDY timeout abort.
RSP_RDATA  out  MEMORY_DATA_WIDTH  read data, valid with RSP_VLD; holds its value until the next read completes.
SI  out  1  serial data to the controller.
LOAD_N  out  1  active-low slot strobe, exactly one cycle low per slot.
CTRL  out  2  slot code: 00 shift, 11 SRAM write, 01 SRAM read.
SO  in  1  serial data from the controller.
RDY  in  1  controller idle.

Behaviour:
- Reset (BGN low, asynchronous): state IDLE, LOAD_N=1, SI=0, CTRL=00, CMD_RDY=1, RSP_VLD=0, RSP_ERR=0, RSP_RDATA=0, all counters 0. Reset mid-command abandons the command with no response.
- CMD_RDY=1 only in IDLE. On the acceptance edge, latch {addr, wdata, wr}. Wdata is forced to 0 for reads.
- Slot structure: slot counter runs 0..SLOT_CYCLES-1.
  - LOAD_N=0 only while the count is 0.
  - SI and CTRL are stable for the whole slot.
  - The slot completes at the first edge with count >= SLOT_CYCLES-1 and RDY=1.
  - LOAD_N returns high between slots; the next slot's count-0 cycle follows immediately.
- If RDY stays 0 for TIMEOUT_CYCLES cycles beyond SLOT_CYCLES-1: abort, pulse RSP_VLD with RSP_ERR=1, go to IDLE, restore LOAD_N=1 and CTRL=00.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT: 17 slots, CTRL=00. SI order: wdata[0]..wdata[7], then addr[0]..addr[8] (LSB first, data first). Bit counter 0..16.
  - EXEC: 1 slot, CTRL=11 for write, 01 for read.
  - Write: EXEC -> DONE.
  - Read: sample SO at EXEC completion into RSP_RDATA bit 0, then go to RDBK.
  - RDBK: 7 slots, CTRL=00, SI=0. At completion of RDBK slot k (1..7), sample SO into bit k. Then go to DONE.
  - DONE: RSP_VLD=1 for one cycle with RSP_ERR=0, then IDLE.
- Response timing with RDY always high: acceptance edge = cycle 0.
  - Write: first LOAD_N low in cycle 1, RSP_VLD in cycle 18*SLOT_CYCLES+1 (109 at default).
  - Read: RSP_VLD in cycle 25*SLOT_CYCLES+1 (151 at default).
- CMD_VLD during a command is ignored; it is not queued.
- Back-to-back: a command presented during the RSP_VLD cycle is accepted on the following cycle (IDLE).
- RSP_RDATA is updated only at DONE of a read; sample assembly uses a shadow register.

Test Plan:
- Reset values: assert BGN low mid-SHIFT -> LOAD_N=1, CTRL=00, CMD_RDY=1, RSP_VLD=0 immediately (asynchronous).
- Write, with a behavioural model of the SRAM serial controller attached: addr=0x1A5, data=0x3C -> 18 LOAD_N pulses, SI stream 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1,1; EXEC CTRL=11; RSP_VLD at cycle 109, RSP_ERR=0; SRAM[0x1A5]=0x3C.
- Read: preload SRAM[0x0FF]=0xA7 -> 25 slots, EXEC CTRL=01, RSP_RDATA=0xA7 at cycle 151.
- Back-to-back: write 0x055<-0xFF, then read 0x055 presented during RSP_VLD -> read accepted next cycle, returns 0xFF.
- Stretched RDY: model holds RDY low 10 extra cycles in slot 3 -> slot lengthens by 10, no error, data correct.
- Timeout: RDY stuck low after the first slot -> RSP_VLD with RSP_ERR=1 after SLOT_CYCLES-1+64 cycles, LOAD_N=1, CMD_RDY=1 next cycle.
